// File: rtl/wires.sv
// Shared types for the memory controller: port request/response structs, FSM and grant enums.
// Latency: n/a (type and function definitions only).
// Backpressure: n/a.
package wires;

    // One memory port as seen from the requester side.
    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
    } mem_out_type;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IMEM = 1'b0,
        GNT_DMEM = 1'b1
    } grant_t;

    // True when a word index fits in a store of 2^abits words.
    function automatic logic word_in_range(input logic [31:0] word, input int abits);
        return (word >> abits) == 32'd0;
    endfunction

endpackage

// File: rtl/memory_ctrl_if.sv
// Instruction and data memory ports of the controller, grouped as one bundle.
// Latency: n/a (wiring only).
// Backpressure: requester holds *_valid until the matching one-cycle *_ready pulse.
// Ports: imemory_* and dmemory_* valid/instr/addr/wdata/wstrb (requester -> controller),
//        rdata/ready (controller -> requester).
interface memory_ctrl_if;
    logic        imemory_valid;
    logic        imemory_instr;
    logic [31:0] imemory_addr;
    logic [31:0] imemory_wdata;
    logic [3:0]  imemory_wstrb;
    logic [31:0] imemory_rdata;
    logic        imemory_ready;

    logic        dmemory_valid;
    logic        dmemory_instr;
    logic [31:0] dmemory_addr;
    logic [31:0] dmemory_wdata;
    logic [3:0]  dmemory_wstrb;
    logic [31:0] dmemory_rdata;
    logic        dmemory_ready;

    modport master (
        output imemory_valid, imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb,
        input  imemory_rdata, imemory_ready,
        output dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb,
        input  dmemory_rdata, dmemory_ready
    );

    modport slave (
        input  imemory_valid, imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb,
        output imemory_rdata, imemory_ready,
        input  dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb,
        output dmemory_rdata, dmemory_ready
    );
endinterface

// File: rtl/sram.sv
// Single-port word store with four byte-write lanes; contents are never reset.
// Latency: read data registered, valid the cycle after an enabled access.
// Backpressure: none; one access per enabled cycle.
// Ports: clk, en (access strobe), we (byte lanes, 0 = read), addr (word index), wdata, rdata.
module sram #(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);
    logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/memory_ctrl.sv
// Two-port (instruction/data) memory controller: round-robin arbiter in front of one sram.
// Latency: request seen in IDLE at cycle t -> one-cycle ready at t + WAIT_CYCLES + 2.
// Backpressure: one request in flight; the other port waits with valid held until granted.
// Ports: clk, rst (sync, active-high), bus (slave side of memory_ctrl_if).
module memory_ctrl import wires::*; #(
    parameter int ADDR_BITS   = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    memory_ctrl_if.slave bus
);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t                state;
    grant_t                gnt;
    grant_t                last_gnt;
    grant_t                gnt_next;
    logic [3:0]            cnt;
    logic [ADDR_BITS-1:0]  word_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  inr_q;
    logic                  iready_q;
    logic                  dready_q;
    logic                  rd_ok_q;
    logic [31:0]           sram_q;
    logic [31:0]           sel_addr;
    logic [31:0]           sel_wdata;
    logic [31:0]           sel_word;
    logic [3:0]            sel_wstrb;
    logic                  sel_inr;
    logic                  mem_en;

    // On a tie the port that did not win last time is served.
    always_comb begin
        gnt_next = GNT_IMEM;
        if (bus.imemory_valid && bus.dmemory_valid) begin
            if (last_gnt == GNT_IMEM) begin
                gnt_next = GNT_DMEM;
            end
        end else if (bus.dmemory_valid) begin
            gnt_next = GNT_DMEM;
        end
    end

    assign sel_addr  = (gnt_next == GNT_DMEM) ? bus.dmemory_addr  : bus.imemory_addr;
    assign sel_wdata = (gnt_next == GNT_DMEM) ? bus.dmemory_wdata : bus.imemory_wdata;
    assign sel_wstrb = (gnt_next == GNT_DMEM) ? bus.dmemory_wstrb : bus.imemory_wstrb;
    // Byte offset bits are dropped; anything above the store size marks the access out of range.
    assign sel_word  = sel_addr >> 2;
    assign sel_inr   = word_in_range(sel_word, ADDR_BITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            gnt      <= GNT_IMEM;
            last_gnt <= GNT_IMEM;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            iready_q <= 1'b0;
            dready_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.imemory_valid || bus.dmemory_valid) begin
                        gnt      <= gnt_next;
                        last_gnt <= gnt_next;
                        cnt      <= WAIT_LOAD;
                        state    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state    <= ST_RESP;
                    iready_q <= (gnt == GNT_IMEM);
                    dready_q <= (gnt == GNT_DMEM);
                    rd_ok_q  <= (wstrb_q == 4'd0) && inr_q;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request payload is only meaningful after a grant, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && (bus.imemory_valid || bus.dmemory_valid)) begin
            word_q  <= sel_word[ADDR_BITS-1:0];
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            inr_q   <= sel_inr;
        end
    end

    // Gating with rst keeps a write from landing if reset coincides with its ACCESS edge.
    assign mem_en = (state == ST_ACCESS) && inr_q && !rst;

    sram #(.ADDR_BITS(ADDR_BITS)) u_sram (
        .clk   (clk),
        .en    (mem_en),
        .we    (wstrb_q),
        .addr  (word_q),
        .wdata (wdata_q),
        .rdata (sram_q)
    );

    assign bus.imemory_ready = iready_q;
    assign bus.dmemory_ready = dready_q;
    // Registered sram word is passed only to the port being answered, and only for in-range reads.
    assign bus.imemory_rdata = (iready_q && rd_ok_q) ? sram_q : 32'h0;
    assign bus.dmemory_rdata = (dready_q && rd_ok_q) ? sram_q : 32'h0;
endmodule
